// File: rtl/clq_walk_ctrl.sv
// Unit-clause walk controller: round-robin arbitration over unit-literal
// requesters, head lookup in the clause queue, then a bounded list walk to the BCP engine.
module clq_walk_ctrl #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned LIT_W    = 8,
  parameter int unsigned PTR_W    = 5,
  parameter int unsigned NODE_W   = 32,
  parameter int unsigned MAX_WALK = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*LIT_W-1:0]   req_lit,
  output logic [NREQ-1:0]         req_ready,
  output logic [LIT_W-1:0]        uc_rqst,
  output logic                    uc_rqst_valid,
  input  logic [PTR_W-1:0]        init_ptr,
  input  logic                    init_ptr_valid,
  output logic [PTR_W-1:0]        cnf_idx,
  input  logic [NODE_W-1:0]       node_in,
  output logic [NODE_W-1:0]       node_out,
  output logic                    node_valid,
  input  logic                    node_ready,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_src,
  output logic                    err_loop,
  output logic                    busy
);

  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(MAX_WALK) + 1;
  localparam logic [PTR_W-1:0] NULL_PTR = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WALK   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  rr_ptr;

  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx;
  int unsigned      scan_idx;

  logic [PTR_W-1:0] next_ptr;
  logic             last_node;
  logic             walk_limit;

  // Round-robin pick: first valid requester at or after rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = (32'(rr_ptr) + k) % NREQ;
      if (!gnt_found && req_valid[ID_W'(scan_idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(scan_idx);
      end
    end
  end

  assign next_ptr   = node_in[PTR_W-1:0];
  assign last_node  = (next_ptr == NULL_PTR);
  assign walk_limit = ((count + CNT_W'(1)) == CNT_W'(MAX_WALK));

  // Clause-queue read data is combinational, so the node is forwarded as it
  // arrives; this is what keeps one node per cycle and holds it while stalled.
  assign node_out = (state == WALK) ? node_in : '0;

  // Controller: cnf_idx doubles as the current-node pointer and is zero outside WALK.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state         <= IDLE;
      count         <= '0;
      id_q          <= '0;
      rr_ptr        <= '0;
      req_ready     <= '0;
      uc_rqst       <= '0;
      uc_rqst_valid <= 1'b0;
      cnf_idx       <= '0;
      node_valid    <= 1'b0;
      done          <= 1'b0;
      done_src      <= '0;
      err_loop      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      req_ready <= '0;
      done      <= 1'b0;
      done_src  <= '0;
      err_loop  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            req_ready     <= NREQ'(1) << gnt_idx;
            uc_rqst       <= req_lit[32'(gnt_idx)*LIT_W +: LIT_W];
            uc_rqst_valid <= 1'b1;
            id_q          <= gnt_idx;
            rr_ptr        <= ID_W'((32'(gnt_idx) + 32'd1) % NREQ);
            busy          <= 1'b1;
            state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (init_ptr_valid) begin
            uc_rqst       <= '0;
            uc_rqst_valid <= 1'b0;
            if (init_ptr != NULL_PTR) begin
              cnf_idx    <= init_ptr;
              count      <= '0;
              node_valid <= 1'b1;
              state      <= WALK;
            end else begin
              done     <= 1'b1;
              done_src <= id_q;
              state    <= DONE;
            end
          end
        end
        WALK: begin
          if (node_ready) begin
            count <= count + CNT_W'(1);
            if (last_node || walk_limit) begin
              cnf_idx    <= '0;
              node_valid <= 1'b0;
              done       <= 1'b1;
              done_src   <= id_q;
              err_loop   <= !last_node;
              state      <= DONE;
            end else begin
              cnf_idx <= next_ptr;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/clq_walk_ctrl.md
CLQ_WALK_CTRL -- requirements
Module: clq_walk_ctrl

Interface
REQ-001 Parameters (name, default, meaning): NREQ, 4, number of unit-clause requesters.
REQ-002 LIT_W, 8, literal width (MSB = polarity).
REQ-003 PTR_W, 5, clause-queue node index width; all-ones value is NULL_PTR (end of list / no list).
REQ-004 NODE_W, 32, node width; bits [PTR_W-1:0] of a node hold its next pointer.
REQ-005 MAX_WALK, 16, maximum nodes emitted per walk (loop guard).
REQ-006 Ports (name, direction, width, meaning): clk, in, 1, sole clock.
REQ-007 rst_n, in, 1, synchronous active-high reset, despite its name.
REQ-008 req_valid, in, NREQ, per-requester unit-literal request pending.
REQ-009 req_lit, in, NREQ*LIT_W, requester i literal at [i*LIT_W +: LIT_W].
REQ-010 req_ready, out, NREQ, one-hot grant pulse; the request is consumed on this cycle.
REQ-011 uc_rqst, out, LIT_W, literal presented to the clause queue for head lookup.
REQ-012 uc_rqst_valid, out, 1, lookup strobe.
REQ-013 init_ptr, in, PTR_W, head pointer returned combinationally by the clause queue.
REQ-014 init_ptr_valid, in, 1, init_ptr is valid.
REQ-015 cnf_idx, out, PTR_W, node index driven to the clause queue; its read data returns combinationally.
REQ-016 node_in, in, NODE_W, node read at cnf_idx.
REQ-017 node_out, out, NODE_W, node forwarded to the BCP engine.
REQ-018 node_valid, out, 1, node_out valid.
REQ-019 node_ready, in, 1, BCP engine accepts node_out.
REQ-020 done, out, 1, one-cycle pulse when a walk ends.
REQ-021 done_src, out, $clog2(NREQ), requester id of the completed walk; valid while done=1.
REQ-022 err_loop, out, 1, valid with done; 1 = walk truncated at MAX_WALK.
REQ-023 busy, out, 1, 1 in every state except IDLE.

Function
REQ-024 FSM states are IDLE, LOOKUP, WALK and DONE.
REQ-025 IDLE, any req_valid: round-robin grant starting at the index after the last granted requester (requester 0 first after reset); pulse req_ready[g]; latch req_lit[g] and g; go to LOOKUP next cycle.
REQ-026 IDLE, no req_valid: remain in IDLE; all outputs 0.
REQ-027 LOOKUP: uc_rqst = latched literal; uc_rqst_valid = 1.
REQ-028 LOOKUP, init_ptr_valid=1 and init_ptr != NULL_PTR: cur_ptr <= init_ptr, count <= 0, go to WALK.
REQ-029 LOOKUP, init_ptr_valid=1 and init_ptr == NULL_PTR: go to DONE; zero nodes emitted.
REQ-030 LOOKUP, init_ptr_valid=0: remain in LOOKUP with the strobe held.
REQ-031 WALK: cnf_idx = cur_ptr; node_out = node_in; node_valid = 1; node_out is held stable until accepted.
REQ-032 WALK, node_ready=1: count increments; cur_ptr <= node_in[PTR_W-1:0].
REQ-033 WALK, node_ready=1 and next == NULL_PTR: go to DONE with err_loop=0.
REQ-034 WALK, node_ready=1, next != NULL_PTR and count+1 == MAX_WALK: go to DONE with err_loop=1.
REQ-035 WALK, node_ready=1 otherwise: stay in WALK; throughput is 1 node/cycle under continuous node_ready.
REQ-036 WALK, node_ready=0: stall; hold cur_ptr and count.
REQ-037 DONE: done=1, done_src = latched id, err_loop per REQ-033/034; go to IDLE next cycle.
REQ-038 Grants occur only in IDLE; requests arriving while busy wait; at most one walk is in flight.
REQ-039 Latency: grant to first node_valid = 2 cycles; last acceptance to done = 1 cycle.
REQ-040 cnf_idx = 0 outside WALK.
REQ-041 count is $clog2(MAX_WALK)+1 bits wide and never wraps.

Reset
REQ-042 rst_n=1 at a clock edge forces IDLE, clears all outputs, cur_ptr, count, latched literal, latched id, and resets the round-robin pointer so requester 0 has priority.
REQ-043 Reset mid-walk abandons the walk with no done pulse; rst_n has priority over all other inputs.

Verification
REQ-044 req_valid=0001, lit=0x03, init_ptr=2; nodes 2->5->NULL_PTR with node_ready=1 -> req_ready[0] pulse, cnf_idx 2 then 5, two node_valid cycles, done=1, done_src=0, err_loop=0.
REQ-045 req_valid=1111 held for 4 walks -> grant order 0,1,2,3; a fifth walk grants 0.
REQ-046 init_ptr=NULL_PTR (0x1F) -> no node_valid, done 1 cycle after LOOKUP.
REQ-047 Self-loop node 4->4, MAX_WALK=16 -> exactly 16 nodes emitted, done=1, err_loop=1.
REQ-048 node_ready held low 3 cycles in WALK -> node_out and cnf_idx stable; count unchanged.
REQ-049 rst_n=1 for one cycle during WALK -> busy=0 next cycle, no done pulse, next grant goes to requester 0.
